// File: rtl/matrix_row_engine.sv
// Row-at-a-time 3x3 matrix multiplier on a single MAC. Each rising edge of an
// unload strobe queues one row of C = A*B, and the row's elements stream out.
module matrix_row_engine #(
  parameter int DW   = 8,
  parameter int ACCW = 2*DW+2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic            load_sel,
  input  logic [3:0]      load_addr,
  input  logic [DW-1:0]   load_data,
  input  logic            unload1,
  input  logic            unload2,
  input  logic            unload3,
  output logic            busy,
  output logic            res_valid,
  output logic [3:0]      res_addr,
  output logic [ACCW-1:0] res_data,
  output logic            row_done,
  output logic            done,
  output logic            err
);

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_WRITE, S_ROWEND} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     a_q [9];
  logic [DW-1:0]     a_d [9];
  logic [DW-1:0]     b_q [9];
  logic [DW-1:0]     b_d [9];
  logic [2:0]        unload_prev_q, unload_prev_d;
  logic [2:0]        pending_q, pending_d;
  logic [2:0]        completed_q, completed_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        row_q, row_d;
  logic [1:0]        col_q, col_d;
  logic [1:0]        m_q, m_d;
  logic [ACCW-1:0]   acc_q, acc_d;

  logic [2:0]        unload_vec, rise, clear;
  logic [1:0]        sel_row;
  logic [3:0]        a_idx, b_idx;
  logic [2*DW-1:0]   prod;
  logic              busy_int;

  assign unload_vec = {unload3, unload2, unload1};
  assign rise       = unload_vec & ~unload_prev_q;
  assign a_idx      = 4'(row_q) * 4'd3 + 4'(m_q);
  assign b_idx      = 4'(m_q) * 4'd3 + 4'(col_q);
  assign prod       = a_q[a_idx] * b_q[b_idx];
  // ROWEND with work queued behaves like IDLE, so the engine stays busy.
  assign busy_int   = (state_q == S_MAC) || (state_q == S_WRITE) ||
                      ((state_q == S_ROWEND) && (pending_q != 3'b000));
  assign sel_row    = pending_q[0] ? 2'd0 : (pending_q[1] ? 2'd1 : 2'd2);

  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    unload_prev_d = unload_vec;
    completed_d   = completed_q;
    err_d         = 1'b0;
    row_d         = row_q;
    col_d         = col_q;
    m_d           = m_q;
    acc_d         = acc_q;
    clear         = 3'b000;

    case (state_q)
      S_IDLE, S_ROWEND: begin
        state_d = S_IDLE;
        if (pending_q != 3'b000) begin
          clear   = 3'b001 << sel_row;
          row_d   = sel_row;
          col_d   = 2'd0;
          m_d     = 2'd0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + ACCW'(prod);
        if (m_q == 2'd2) begin
          m_d     = 2'd0;
          state_d = S_WRITE;
        end else begin
          m_d = m_q + 2'd1;
        end
      end
      S_WRITE: begin
        acc_d = '0;
        if (col_q == 2'd2) begin
          completed_d[row_q] = 1'b1;
          state_d            = S_ROWEND;
        end else begin
          col_d   = col_q + 2'd1;
          state_d = S_MAC;
        end
      end
      default: state_d = S_IDLE;
    endcase

    pending_d = (pending_q & ~clear) | rise;

    if (load_en) begin
      if (busy_int || (load_addr > 4'd8)) begin
        err_d = 1'b1;
      end else begin
        if (load_sel) b_d[load_addr] = load_data;
        else          a_d[load_addr] = load_data;
        completed_d = 3'b000;
      end
    end

    done_d = (completed_d == 3'b111);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      for (int k = 0; k < 9; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
      end
      unload_prev_q <= '0;
      pending_q     <= '0;
      completed_q   <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      row_q         <= '0;
      col_q         <= '0;
      m_q           <= '0;
      acc_q         <= '0;
    end else begin
      state_q       <= state_d;
      a_q           <= a_d;
      b_q           <= b_d;
      unload_prev_q <= unload_prev_d;
      pending_q     <= pending_d;
      completed_q   <= completed_d;
      done_q        <= done_d;
      err_q         <= err_d;
      row_q         <= row_d;
      col_q         <= col_d;
      m_q           <= m_d;
      acc_q         <= acc_d;
    end
  end

  assign busy      = busy_int;
  assign res_valid = (state_q == S_WRITE);
  assign res_addr  = res_valid ? (4'(row_q) * 4'd3 + 4'(col_q)) : 4'd0;
  assign res_data  = res_valid ? acc_q : '0;
  assign row_done  = (state_q == S_ROWEND);
  assign done      = done_q;
  assign err       = err_q;

endmodule
